// File: rtl/magnetron_pwr_ctrl.sv
// Magnetron power controller: cook FSM, duty-cycle power window,
// timed end-of-cook beep and same-cycle door interlock.
module magnetron_pwr_ctrl #(
    parameter int PWR_W    = 4,
    parameter int PERIOD   = 8,
    parameter int DONE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startn,
    input  logic             stopn,
    input  logic             clearn,
    input  logic             door_closed,
    input  logic             timer_done,
    input  logic [PWR_W-1:0] pwr_lvl,
    output logic             mag_on,
    output logic             beep,
    output logic [1:0]       state,
    output logic             busy
);

    localparam int PH_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int PQ_W  = $clog2(PERIOD + 1);
    localparam int BC_W  = $clog2(DONE_CYC + 1);
    localparam int CMP_W = (PWR_W > PQ_W) ? PWR_W : PQ_W;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COOK  = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t          st, st_n;
    logic [PH_W-1:0] phase, ph_n;
    logic [PQ_W-1:0] pwr_q, pq_n;
    logic [BC_W-1:0] beep_cnt, bc_n;
    logic            startn_q;

    logic             start_evt;
    logic             lock;
    logic [CMP_W-1:0] lvl_ext;
    logic [PQ_W-1:0]  pwr_clamp;

    assign start_evt = startn_q & ~startn;
    assign lock      = ~door_closed | ~stopn;
    assign lvl_ext   = CMP_W'(pwr_lvl);

    // Levels above PERIOD saturate to full duty
    assign pwr_clamp = (lvl_ext > CMP_W'(PERIOD)) ?
                       PQ_W'(PERIOD) : PQ_W'(lvl_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            phase    <= '0;
            pwr_q    <= '0;
            beep_cnt <= '0;
            startn_q <= 1'b1;
        end else begin
            st       <= st_n;
            phase    <= ph_n;
            pwr_q    <= pq_n;
            beep_cnt <= bc_n;
            startn_q <= startn;
        end
    end

    always_comb begin
        st_n = st;
        ph_n = phase;
        pq_n = pwr_q;
        bc_n = beep_cnt;
        unique case (st)
            IDLE: begin
                if (clearn && !lock && !timer_done && start_evt) begin
                    st_n = COOK;
                    ph_n = '0;
                    pq_n = pwr_clamp;
                end
            end
            COOK: begin
                if (!clearn) begin
                    st_n = IDLE;
                end else if (lock) begin
                    st_n = PAUSE;
                end else if (timer_done) begin
                    st_n = DONE;
                    bc_n = BC_W'(DONE_CYC);
                end else if (phase == PH_W'(PERIOD - 1)) begin
                    ph_n = '0;
                end else begin
                    ph_n = phase + 1'b1;
                end
            end
            PAUSE: begin
                if (!clearn) begin
                    st_n = IDLE;
                end else if (lock) begin
                    st_n = PAUSE;
                end else if (timer_done) begin
                    st_n = DONE;
                    bc_n = BC_W'(DONE_CYC);
                end else if (start_evt) begin
                    st_n = COOK;
                    ph_n = '0;
                end
            end
            DONE: begin
                if (!clearn) begin
                    st_n = IDLE;
                    bc_n = '0;
                end else begin
                    bc_n = beep_cnt - 1'b1;
                    if (beep_cnt == BC_W'(1)) begin
                        st_n = IDLE;
                    end
                end
            end
        endcase
    end

    // door_closed gates the enable directly so it drops before PAUSE
    assign mag_on = (st == COOK) && (PQ_W'(phase) < pwr_q) && door_closed;
    assign beep   = (st == DONE);
    assign busy   = (st == COOK) || (st == PAUSE);
    assign state  = st;

endmodule

// File: tb/tb_magnetron_pwr_ctrl.sv
// Randomised and directed bench for magnetron_pwr_ctrl against
// a cycle-level reference model of the cook rules.
module tb_magnetron_pwr_ctrl;

    localparam int PWR_W    = 4;
    localparam int PERIOD   = 8;
    localparam int DONE_CYC = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             startn;
    logic             stopn;
    logic             clearn;
    logic             door_closed;
    logic             timer_done;
    logic [PWR_W-1:0] pwr_lvl;
    logic             mag_on;
    logic             beep;
    logic [1:0]       state;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: 0 idle, 1 cook, 2 pause, 3 done
    int m_st;
    int m_ph;
    int m_pw;
    int m_left;
    bit m_sq;

    magnetron_pwr_ctrl #(
        .PWR_W(PWR_W),
        .PERIOD(PERIOD),
        .DONE_CYC(DONE_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .startn(startn),
        .stopn(stopn),
        .clearn(clearn),
        .door_closed(door_closed),
        .timer_done(timer_done),
        .pwr_lvl(pwr_lvl),
        .mag_on(mag_on),
        .beep(beep),
        .state(state),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0;
        m_ph = 0;
        m_pw = 0;
        m_left = 0;
        m_sq = 1'b1;
    endtask

    task automatic model_clk();
        bit sev;
        bit lk;
        sev = m_sq && !startn;
        lk = !door_closed || !stopn;
        case (m_st)
            0: if (clearn && !lk && !timer_done && sev) begin
                m_st = 1;
                m_ph = 0;
                m_pw = (int'(pwr_lvl) > PERIOD) ? PERIOD : int'(pwr_lvl);
            end
            1: if (!clearn) m_st = 0;
               else if (lk) m_st = 2;
               else if (timer_done) begin
                   m_st = 3;
                   m_left = DONE_CYC;
               end else m_ph = (m_ph + 1) % PERIOD;
            2: if (!clearn) m_st = 0;
               else if (lk) m_st = 2;
               else if (timer_done) begin
                   m_st = 3;
                   m_left = DONE_CYC;
               end else if (sev) begin
                   m_st = 1;
                   m_ph = 0;
               end
            default: if (!clearn) m_st = 0;
               else begin
                   m_left--;
                   if (m_left == 0) m_st = 0;
               end
        endcase
        m_sq = startn;
    endtask

    task automatic check_outs();
        int exp_mag;
        exp_mag = (m_st == 1 && m_ph < m_pw && door_closed) ? 1 : 0;
        check("mag_on", int'(mag_on), exp_mag);
        check("beep", int'(beep), (m_st == 3) ? 1 : 0);
        check("busy", int'(busy), (m_st == 1 || m_st == 2) ? 1 : 0);
        check("state", int'(state), m_st);
    endtask

    task automatic cyc(input bit s, input bit sp, input bit cl,
                       input bit d, input bit t, input int p);
        @(negedge clk);
        startn = s;
        stopn = sp;
        clearn = cl;
        door_closed = d;
        timer_done = t;
        pwr_lvl = PWR_W'(p);
        #1;
        check_outs();
        @(posedge clk);
        model_clk();
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) cyc(1, 1, 1, 1, 0, 0);
    endtask

    task automatic start_pwr(input int p);
        cyc(1, 1, 1, 1, 0, p);
        cyc(0, 1, 1, 1, 0, p);
    endtask

    task automatic clear_all();
        cyc(1, 1, 0, 1, 0, 0);
        idle_cyc(1);
    endtask

    initial begin
        logic [7:0] pat;
        bit s;
        rst = 1'b1;
        startn = 1'b1;
        stopn = 1'b1;
        clearn = 1'b1;
        door_closed = 1'b1;
        timer_done = 1'b0;
        pwr_lvl = '0;
        model_reset();
        #12;
        check("rst_mag", int'(mag_on), 0);
        check("rst_beep", int'(beep), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_state", int'(state), 0);
        @(negedge clk);
        rst = 1'b0;
        idle_cyc(2);

        // power 3: duty pattern 1,1,1,0,0,0,0,0 with startn held low
        start_pwr(3);
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 1, 1, 0, 3);
            pat[i] = mag_on;
            if (i == 0) check("st_cook", int'(state), 1);
        end
        check("duty3", int'(pat), 8'h07);
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 1, 0, 3);
        check("no_restart", int'(state), 1);
        clear_all();

        // full power, door open, resume keeps power
        start_pwr(8);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 0, 8);
        cyc(1, 1, 1, 0, 0, 8);
        check("door_mag", int'(mag_on), 0);
        cyc(1, 1, 1, 0, 0, 8);
        check("st_pause", int'(state), 2);
        cyc(1, 1, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(1, 1, 1, 1, 0, 0);
            check("resume_full", int'(mag_on), 1);
        end

        // timer expiry: beep 4 cycles, start edge ignored
        cyc(1, 1, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc((i % 2) == 0, 1, 1, 1, 0, 0);
            check("beep_on", int'(beep), 1);
        end
        cyc(0, 1, 1, 1, 0, 0);
        check("beep_end", int'(state), 0);
        idle_cyc(2);

        // saturation and zero power
        start_pwr(15);
        for (int i = 0; i < 10; i++) cyc(1, 1, 1, 1, 0, 15);
        clear_all();
        start_pwr(0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 1, 1, 0, 0);
        check("zero_busy", int'(busy), 1);
        clear_all();

        // blocked starts in idle
        cyc(1, 1, 1, 0, 0, 5);
        cyc(0, 1, 1, 0, 0, 5);
        cyc(1, 1, 1, 1, 1, 5);
        cyc(0, 1, 1, 1, 1, 5);
        cyc(1, 0, 1, 1, 0, 5);
        cyc(0, 0, 1, 1, 0, 5);
        cyc(1, 1, 1, 1, 0, 5);
        check("blocked", int'(state), 0);

        // clear from pause and from done
        start_pwr(4);
        cyc(1, 0, 1, 1, 0, 4);
        cyc(1, 0, 0, 1, 0, 4);
        cyc(1, 1, 1, 1, 0, 4);
        check("clr_pause", int'(state), 0);
        start_pwr(4);
        cyc(1, 1, 1, 1, 1, 4);
        cyc(1, 1, 0, 1, 0, 4);
        cyc(1, 1, 1, 1, 0, 4);
        check("clr_done", int'(state), 0);

        // async reset mid-cook
        start_pwr(8);
        cyc(1, 1, 1, 1, 0, 8);
        @(negedge clk);
        #2;
        check("pre_rst_mag", int'(mag_on), 1);
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_mag", int'(mag_on), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_beep", int'(beep), 0);
        check("arst_state", int'(state), 0);
        @(negedge clk);
        rst = 1'b0;
        idle_cyc(4);
        check("post_rst", int'(state), 0);
        start_pwr(2);
        cyc(1, 1, 1, 1, 0, 2);
        check("post_rst_go", int'(state), 1);

        // random phase
        s = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) s = ~s;
            cyc(s,
                $urandom_range(0, 15) != 0,
                $urandom_range(0, 40) != 0,
                $urandom_range(0, 15) != 0,
                $urandom_range(0, 12) == 0,
                int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
